// File: rtl/add_seq_ctrl_pkg.sv
// rtl/add_seq_ctrl_pkg.sv - shared types and sizing helpers for the add sequencer
package add_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Requester id width: max(1, clog2(R))
    function automatic int calc_idw(input int r);
        return clog2_min1(r);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// rtl/add_seq_ctrl_if.sv - requester/result bundle; res_ovf exists only with ADD_SEQ_CTRL_OVF_EN
interface add_seq_ctrl_if #(
    parameter int N = 4,
    parameter int W = 4,
    parameter int R = 2
) ();
    import add_seq_ctrl_pkg::*;

    localparam int IDW = calc_idw(R);

    logic [R-1:0]       req_valid;
    logic [R-1:0]       req_ready;
    logic [R*W*N-1:0]   req_a;
    logic [R*W*N-1:0]   req_b;
    logic [R-1:0]       req_ci;
    logic               res_valid;
    logic               res_ready;
    logic [W*N:0]       res_sum;
    logic [IDW-1:0]     res_id;
`ifdef ADD_SEQ_CTRL_OVF_EN
    logic               res_ovf;
`endif

    modport slave (
        input  req_valid, req_a, req_b, req_ci, res_ready,
`ifdef ADD_SEQ_CTRL_OVF_EN
        output res_ovf,
`endif
        output req_ready, res_valid, res_sum, res_id
    );

    modport master (
        output req_valid, req_a, req_b, req_ci, res_ready,
`ifdef ADD_SEQ_CTRL_OVF_EN
        input  res_ovf,
`endif
        input  req_ready, res_valid, res_sum, res_id
    );

endinterface

// File: rtl/add.sv
// rtl/add.sv - N-bit ripple-carry adder; s[N] and co both carry the final carry
module add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N:0]   s,
    output logic         co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        s[N] = c;
    end

    assign co = s[N];

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - round-robin sequencer sharing one N-bit adder for W*N-bit sums
// Optional signed-overflow output enabled by ADD_SEQ_CTRL_OVF_EN.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4,
    parameter int R = 2
) (
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus
);

    localparam int IDW = calc_idw(R);
    localparam int KW  = clog2_min1(W);
    localparam int WN  = W * N;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [WN-1:0]   a_q, a_d, b_q, b_d;
    logic [WN:0]     sum_q, sum_d;
`ifdef ADD_SEQ_CTRL_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic            any_req;
    logic [IDW-1:0]  grant;
    logic [R-1:0]    req_ready_c;
    logic [N-1:0]    add_a, add_b;
    logic [N:0]      add_s;
    logic            add_co_unused;

    // First pending requester after the last one served, wrapping at R
    always_comb begin
        int idx;
        any_req = 1'b0;
        grant   = '0;
        idx     = 0;
        for (int i = 0; i < R; i++) begin
            idx = int'(last_grant_q) + 1 + i;
            if (idx >= R) idx = idx - R;
            if (!any_req && bus.req_valid[idx]) begin
                any_req = 1'b1;
                grant   = IDW'(idx);
            end
        end
    end

    assign add_a = a_q[k_q*N +: N];
    assign add_b = b_q[k_q*N +: N];

    add #(.N(N)) u_add (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co_unused)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        k_d          = k_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
`ifdef ADD_SEQ_CTRL_OVF_EN
        ovf_d        = ovf_q;
`endif
        req_ready_c  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready_c[grant] = 1'b1;
                    a_d     = bus.req_a[grant*WN +: WN];
                    b_d     = bus.req_b[grant*WN +: WN];
                    carry_d = bus.req_ci[grant];
                    id_d    = grant;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*N +: N] = add_s[N-1:0];
                carry_d = add_s[N];
                k_d     = k_q + 1'b1;
                if (k_q == KW'(W - 1)) begin
                    sum_d[WN] = add_s[N];
                    k_d       = '0;
                    state_d   = DONE;
`ifdef ADD_SEQ_CTRL_OVF_EN
                    // Top sum bit comes from this final word
                    ovf_d = (a_q[WN-1] == b_q[WN-1]) && (add_s[N-1] != a_q[WN-1]);
`endif
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d      = IDLE;
                    last_grant_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(R - 1);
            id_q         <= '0;
            k_q          <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
`ifdef ADD_SEQ_CTRL_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
`ifdef ADD_SEQ_CTRL_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.req_ready = rst ? '0 : req_ready_c;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = sum_q;
    assign bus.res_id    = id_q;
`ifdef ADD_SEQ_CTRL_OVF_EN
    assign bus.res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - directed bench for add_seq_ctrl (N=4, W=4, R=2); checks res_ovf under ADD_SEQ_CTRL_OVF_EN
module tb_add_seq_ctrl;
    import add_seq_ctrl_pkg::*;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int R   = 2;
    localparam int WN  = W * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_seq_ctrl_if #(.N(N), .W(W), .R(R)) bus ();

    add_seq_ctrl #(.N(N), .W(W), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          r;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; requesters in 'extra' also raise valid
    task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [R-1:0] extra,
                          input logic [16:0] exp_sum, input logic exp_ovf, input string tag);
        int lat;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        bus.req_ci = R'($urandom);
        bus.req_a[r*WN +: WN] = a;
        bus.req_b[r*WN +: WN] = b;
        bus.req_ci[r] = ci;
        bus.req_valid = extra;
        bus.req_valid[r] = 1'b1;
        #1;
        chk({tag, " req_ready"}, bus.req_ready, 64'(1 << r));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        wait_valid(lat);
        chk({tag, " latency"}, lat, W + 1);
        chk({tag, " sum"}, bus.res_sum, exp_sum);
        chk({tag, " id"}, bus.res_id, r);
`ifdef ADD_SEQ_CTRL_OVF_EN
        chk({tag, " ovf"}, bus.res_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) n_chk = n_chk;
`endif
        handshake();
    endtask

    initial begin
        int lat, acc, res_cnt, last_acc, cyc;

        vecs[0] = '{0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
        vecs[1] = '{1, 16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b0};
        vecs[2] = '{0, 16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0};
        vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0};
        vecs[4] = '{0, 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1};
        vecs[5] = '{1, 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1};
        vecs[6] = '{0, 16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0};
        vecs[7] = '{1, 16'hABCD, 16'h1111, 1'b0, 17'h0BCDE, 1'b0};

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_ci = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("req_ready in rst", bus.req_ready, 0);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("reset res_valid", bus.res_valid, 0);
        chk("reset res_sum", bus.res_sum, 0);
        chk("reset res_id", bus.res_id, 0);
        chk("reset req_ready", bus.req_ready, 0);
`ifdef ADD_SEQ_CTRL_OVF_EN
        chk("reset res_ovf", bus.res_ovf, 0);
`endif

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].ci, '0,
                   vecs[i].sum, vecs[i].ovf, $sformatf("vec%0d", i));

        // Strict rotation with both requesters always pending
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_a = {16'h8000, 16'h0102};
        bus.req_b = {16'h9000, 16'h0304};
        bus.req_ci = 2'b10;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        acc = 0; res_cnt = 0; last_acc = 0; cyc = 0;
        while (res_cnt < 6 && cyc < 100) begin
            #1;
            if (bus.req_ready != '0) begin
                chk($sformatf("rot grant%0d", acc), bus.req_ready, 64'(1 << (acc % 2)));
                if (acc > 0) chk($sformatf("rot interval%0d", acc), cyc - last_acc, W + 2);
                last_acc = cyc;
                acc++;
            end
            if (bus.res_valid) begin
                chk($sformatf("rot id%0d", res_cnt), bus.res_id, res_cnt % 2);
                chk($sformatf("rot sum%0d", res_cnt), bus.res_sum,
                    (res_cnt % 2 == 0) ? 64'h00406 : 64'h11001);
                res_cnt++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc == 6) bus.req_valid = '0;
        end
        chk("rot result count", res_cnt, 6);
        bus.res_ready = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);

        // Backpressure in DONE with a competing request pending
        bus.req_a = {16'h0F0F, 16'h1111};
        bus.req_b = {16'h00F1, 16'h2222};
        bus.req_ci = 2'b00;
        bus.req_valid = 2'b01;
        #1;
        chk("stall accept0", bus.req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b10;
        wait_valid(lat);
        chk("stall latency", lat, W + 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d valid", i), bus.res_valid, 1);
            chk($sformatf("stall%0d sum", i), bus.res_sum, 17'h03333);
            chk($sformatf("stall%0d id", i), bus.res_id, 0);
            chk($sformatf("stall%0d req_ready", i), bus.req_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        handshake();
        #1;
        chk("stall next accept", bus.req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        wait_valid(lat);
        chk("stall2 sum", bus.res_sum, 17'h01000);
        chk("stall2 id", bus.res_id, 1);
        handshake();

        // Reset during the second RUN cycle discards the operation
        bus.req_a[WN +: WN] = 16'hAAAA;
        bus.req_b[WN +: WN] = 16'h5555;
        bus.req_ci = 2'b10;
        bus.req_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort res_valid", bus.res_valid, 0);
        chk("abort res_sum", bus.res_sum, 0);
        chk("abort res_id", bus.res_id, 0);
        @(negedge clk);
        run_op(0, 16'h0F00, 16'h0100, 1'b0, 2'b10, 17'h01000, 1'b0, "post-abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
